// File: rtl/dvi_timing_pkg.sv
// Shared types, default 640x480@60 timing and helpers for the DVI timing sequencer.
package dvi_timing_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  localparam int unsigned CntW = 10;

  localparam int unsigned DefHVisible = 640;
  localparam int unsigned DefHFront   = 16;
  localparam int unsigned DefHSync    = 96;
  localparam int unsigned DefHBack    = 48;
  localparam int unsigned DefVVisible = 480;
  localparam int unsigned DefVFront   = 10;
  localparam int unsigned DefVSync    = 2;
  localparam int unsigned DefVBack    = 33;

  function automatic int unsigned h_total(int unsigned vis, int unsigned front,
                                          int unsigned sync, int unsigned back);
    return vis + front + sync + back;
  endfunction

  function automatic int unsigned v_total(int unsigned vis, int unsigned front,
                                          int unsigned sync, int unsigned back);
    return vis + front + sync + back;
  endfunction

  // Bar order white..black maps to inverted {G,R,B} bits of the bar index.
  function automatic logic [23:0] bar_colour(logic [2:0] idx);
    logic [7:0] r, g, b;
    r = {8{~idx[1]}};
    g = {8{~idx[2]}};
    b = {8{~idx[0]}};
    return {r, g, b};
  endfunction

endpackage

// File: rtl/dvi_timing_counter.sv
// Wrapping counter 0..Max with synchronous clear and a carry-out on wrap.
module dvi_timing_counter #(
  parameter int unsigned Width = 10,
  parameter int unsigned Max   = 799
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o,
  output logic             last_o,
  output logic             carry_o
);

  localparam logic [Width-1:0] MaxV = Width'(Max);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = last_o ? '0 : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign last_o  = (cnt_q == MaxV);
  assign carry_o = inc_i & last_o;

endmodule

// File: rtl/dvi_timing_ctrl.sv
// Video timing sequencer: sync/de generation, pixel pull and frame-aligned run/stop.
// Optional colour-bar generator enabled by defining DVI_TIMING_PATTERN_EN.
module dvi_timing_ctrl
  import dvi_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE    = DefHVisible,
  parameter int unsigned H_FRONT      = DefHFront,
  parameter int unsigned H_SYNC       = DefHSync,
  parameter int unsigned H_BACK       = DefHBack,
  parameter int unsigned V_VISIBLE    = DefVVisible,
  parameter int unsigned V_FRONT      = DefVFront,
  parameter int unsigned V_SYNC       = DefVSync,
  parameter int unsigned V_BACK       = DefVBack,
  parameter logic        HSYNC_ACTIVE = 1'b0,
  parameter logic        VSYNC_ACTIVE = 1'b0
) (
  input  logic             pixclk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pattern_sel,
  output logic             pix_req,
  input  logic             pix_valid,
  input  logic [23:0]      pix_data,
  output logic [23:0]      rgb,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic [CntW-1:0]  x,
  output logic [CntW-1:0]  y,
  output logic             frame_start,
  output logic             line_start,
  output logic             underflow
);

  localparam int unsigned HTotal = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned VTotal = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CntW-1:0] HVis     = CntW'(H_VISIBLE);
  localparam logic [CntW-1:0] VVis     = CntW'(V_VISIBLE);
  localparam logic [CntW-1:0] HSyncBeg = CntW'(H_VISIBLE + H_FRONT);
  localparam logic [CntW-1:0] HSyncEnd = CntW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CntW-1:0] VSyncBeg = CntW'(V_VISIBLE + V_FRONT);
  localparam logic [CntW-1:0] VSyncEnd = CntW'(V_VISIBLE + V_FRONT + V_SYNC);

  state_e state_d, state_q;

  logic [CntW-1:0] h_cnt, v_cnt;
  logic            h_last, h_carry, v_last, v_carry;
  logic            frame_last;
  logic            running, start;
  logic            active, visible, pat_on;
  logic [23:0]     pixel_src;

  logic            de_d, de_q;
  logic [23:0]     rgb_d, rgb_q;
  logic [CntW-1:0] x_d, x_q, y_d, y_q;
  logic            hsync_d, hsync_q, vsync_d, vsync_q;
  logic            frame_start_d, frame_start_q;
  logic            line_start_d, line_start_q;
  logic            underflow_d, underflow_q;

  // Counters only move outside IDLE, so the first RUN cycle presents pixel (0,0).
  dvi_timing_counter #(
    .Width(CntW),
    .Max  (HTotal - 1)
  ) u_h_cnt (
    .clk_i  (pixclk),
    .rst_i  (reset),
    .clr_i  (~running),
    .inc_i  (running),
    .cnt_o  (h_cnt),
    .last_o (h_last),
    .carry_o(h_carry)
  );

  dvi_timing_counter #(
    .Width(CntW),
    .Max  (VTotal - 1)
  ) u_v_cnt (
    .clk_i  (pixclk),
    .rst_i  (reset),
    .clr_i  (~running),
    .inc_i  (h_carry),
    .cnt_o  (v_cnt),
    .last_o (v_last),
    .carry_o(v_carry)
  );

  logic unused_v_carry;
  assign unused_v_carry = v_carry;
  assign frame_last     = h_last & v_last;

  // FSM: state register
  always_ff @(posedge pixclk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = frame_last ? StIdle : StDrain;
      StDrain: begin
        if (enable) begin
          state_d = StRun;
        end else if (frame_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    running = (state_q != StIdle);
    start   = (state_q == StIdle) && enable;
  end

`ifdef DVI_TIMING_PATTERN_EN
  localparam logic [CntW-1:0] BarW = CntW'(H_VISIBLE / 8);
  logic [23:0] bar_rgb;
  assign pat_on  = pattern_sel;
  assign bar_rgb = bar_colour(3'(h_cnt / BarW));
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign pat_on             = 1'b0;
`endif

  always_comb begin
    active  = (h_cnt < HVis) && (v_cnt < VVis);
    visible = running && active;
    pix_req = visible && !pat_on;
`ifdef DVI_TIMING_PATTERN_EN
    if (pat_on) begin
      pixel_src = bar_rgb;
    end else begin
      pixel_src = pix_valid ? pix_data : 24'h0;
    end
`else
    pixel_src = pix_valid ? pix_data : 24'h0;
`endif
  end

  always_comb begin
    de_d          = visible;
    rgb_d         = visible ? pixel_src : 24'h0;
    x_d           = h_cnt;
    y_d           = v_cnt;
    hsync_d       = (running && h_cnt >= HSyncBeg && h_cnt < HSyncEnd) ? HSYNC_ACTIVE
                                                                        : ~HSYNC_ACTIVE;
    vsync_d       = (running && v_cnt >= VSyncBeg && v_cnt < VSyncEnd) ? VSYNC_ACTIVE
                                                                        : ~VSYNC_ACTIVE;
    frame_start_d = visible && (h_cnt == '0) && (v_cnt == '0);
    line_start_d  = visible && (h_cnt == '0);
    underflow_d   = underflow_q;
    if (start) begin
      underflow_d = 1'b0;
    end else if (pix_req && !pix_valid) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      de_q          <= 1'b0;
      rgb_q         <= 24'h0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~HSYNC_ACTIVE;
      vsync_q       <= ~VSYNC_ACTIVE;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      de_q          <= de_d;
      rgb_q         <= rgb_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign de          = de_q;
  assign rgb         = rgb_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Bench for dvi_timing_ctrl on a reduced raster; reference model tracks a linear frame position.
module tb_dvi_timing_ctrl;

  localparam int HV = 16, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset, enable, pattern_sel, pix_valid;
  logic [23:0] pix_data;
  logic        pix_req, de, hsync, vsync, frame_start, line_start, underflow;
  logic [23:0] rgb;
  logic [9:0]  x, y;

  always #5 clk = ~clk;

  dvi_timing_ctrl #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0)
  ) dut (
    .pixclk     (clk),
    .reset      (reset),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .pix_req    (pix_req),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .rgb        (rgb),
    .de         (de),
    .hsync      (hsync),
    .vsync      (vsync),
    .x          (x),
    .y          (y),
    .frame_start(frame_start),
    .line_start (line_start),
    .underflow  (underflow)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: 0 idle, 1 run, 2 drain; position is a linear index into the frame.
  int          m_state = 0;
  int          m_p     = 0;
  logic        e_de = 0, e_hs = 1, e_vs = 1, e_fs = 0, e_ls = 0, e_uf = 0;
  logic [23:0] e_rgb = 0;
  int          e_x = 0, e_y = 0;

  int c_de, c_fs, c_ls, c_hs, c_vs;

  function automatic int mh();
    return m_p % HT;
  endfunction

  function automatic int mv();
    return m_p / HT;
  endfunction

  function automatic logic [23:0] bar(int col);
    int b;
    b = col / (HV / 8);
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input bit valid, input bit psel,
                     input logic [23:0] data);
    int  h, v;
    bit  act, req, last, pe;
    reset = rst; enable = en; pix_valid = valid; pattern_sel = psel; pix_data = data;
`ifdef DVI_TIMING_PATTERN_EN
    pe = psel;
`else
    pe = 1'b0;
`endif
    h    = mh();
    v    = mv();
    act  = (m_state != 0) && h < HV && v < VV;
    req  = act && !pe;
    last = (m_p == FRAME - 1);
    #1;
    chk("pix_req", 32'(pix_req), 32'(req));
    if (rst) begin
      m_state = 0; m_p = 0;
      e_de = 0; e_rgb = 0; e_x = 0; e_y = 0; e_hs = 1; e_vs = 1;
      e_fs = 0; e_ls = 0; e_uf = 0;
    end else begin
      e_de  = act;
      e_rgb = act ? (pe ? bar(h) : (valid ? data : 24'h0)) : 24'h0;
      e_x   = h;
      e_y   = v;
      e_hs  = !((m_state != 0) && h >= HV + HF && h < HV + HF + HS);
      e_vs  = !((m_state != 0) && v >= VV + VF && v < VV + VF + VS);
      e_fs  = act && (m_p == 0);
      e_ls  = act && (h == 0);
      if (m_state == 0 && en) e_uf = 0;
      else if (req && !valid) e_uf = 1;
      case (m_state)
        0: if (en) m_state = 1;
        1: begin
          m_p = (m_p + 1) % FRAME;
          if (!en) m_state = last ? 0 : 2;
        end
        default: begin
          m_p = (m_p + 1) % FRAME;
          if (en) m_state = 1;
          else if (last) m_state = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
    chk("de", 32'(de), 32'(e_de));
    chk("rgb", 32'(rgb), 32'(e_rgb));
    chk("x", 32'(x), 32'(e_x));
    chk("y", 32'(y), 32'(e_y));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("line_start", 32'(line_start), 32'(e_ls));
    chk("underflow", 32'(underflow), 32'(e_uf));
    c_de += int'(de); c_fs += int'(frame_start); c_ls += int'(line_start);
    c_hs += int'(!hsync); c_vs += int'(!vsync);
  endtask

  task automatic run(input bit en, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, en, 1'b1, 1'b0, 24'($urandom));
  endtask

  initial begin
    reset = 1; enable = 0; pattern_sel = 0; pix_valid = 0; pix_data = 0;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 24'h0);
    run(1'b0, 3);

    // Two full frames: aggregate counts against raster arithmetic.
    c_de = 0; c_fs = 0; c_ls = 0; c_hs = 0; c_vs = 0;
    run(1'b1, 2 * FRAME + 1);
    chk("de_count", 32'(c_de), 32'(2 * HV * VV));
    chk("frame_start_count", 32'(c_fs), 32'(2));
    chk("line_start_count", 32'(c_ls), 32'(2 * VV));
    chk("hsync_low_count", 32'(c_hs), 32'(2 * VT * HS));
    chk("vsync_low_count", 32'(c_vs), 32'(2 * VS * HT));

    // Stop mid-frame, resume during drain, then stop for real.
    for (int g = 0; g < 2 * FRAME && mv() != 2; g++) run(1'b1, 1);
    for (int g = 0; g < 2 * FRAME && mv() != 4; g++) run(1'b0, 1);
    chk("drain_state", 32'(m_state), 32'd2);
    run(1'b1, 5);
    for (int g = 0; g < 2 * FRAME && m_state != 0; g++) run(1'b0, 1);
    run(1'b0, 6);
    chk("idle_after_drain", 32'(m_state), 32'd0);

    // Underflow: three missing pixels at (10,5), sticky until next start.
    run(1'b1, 2);
    for (int g = 0; g < 2 * FRAME && !(mh() == 10 && mv() == 5); g++) run(1'b1, 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'($urandom));
    chk("underflow_set", 32'(underflow), 32'd1);
    run(1'b1, 20);
    for (int g = 0; g < 2 * FRAME && m_state != 0; g++) run(1'b0, 1);
    run(1'b0, 2);
    chk("underflow_sticky_idle", 32'(underflow), 32'd1);
    run(1'b1, 2);
    chk("underflow_cleared", 32'(underflow), 32'd0);

    // Reset inside hsync, then stay idle until enable.
    for (int g = 0; g < 2 * FRAME && mh() != HV + HF + 1; g++) run(1'b1, 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 24'h0);
    run(1'b0, 8);
    run(1'b1, FRAME / 2);

    // Random enable/valid traffic.
    for (int i = 0; i < 3000; i++)
      cyc(1'b0, ($urandom_range(0, 99) < 97), ($urandom_range(0, 9) != 0), 1'b0,
          24'($urandom));

`ifdef DVI_TIMING_PATTERN_EN
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
    for (int i = 0; i < FRAME + 2; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'($urandom));
    chk("pattern_underflow", 32'(underflow), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
